// File: rtl/gpr_wb_ctrl_if.sv
// Bundle of issue, result-producer and register-file write-port signals
// around the GPR write-back controller.
interface gpr_wb_ctrl_if #(
  parameter int XLEN = 32
);
  // Issue stage
  logic            iss_valid;
  logic            iss_wen;
  logic [4:0]      iss_rd;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic            iss_ready;

  // EXU result bus
  logic            exu_valid;
  logic [4:0]      exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            exu_ready;

  // LSU result bus
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  // Register file write port and status
  logic            reg_write;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            idle;
  logic            err;

  // The controller side
  modport slave (
    input  iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2,
    output iss_ready,
    input  exu_valid, exu_rd, exu_data,
    output exu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output reg_write, rd_addr, rd_data, idle, err
  );

  // The pipeline side: issue stage, producers, register file
  modport master (
    output iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2,
    input  iss_ready,
    output exu_valid, exu_rd, exu_data,
    input  exu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  reg_write, rd_addr, rd_data, idle, err
  );
endinterface

// File: rtl/gpr_wb_ctrl.sv
// Write-back controller and busy scoreboard for the 32 x 32-bit GPR file.
// Round-robin arbitration of EXU/LSU results onto one registered write port;
// RAW/WAW hazards stall issue until the producing write has been performed.
module gpr_wb_ctrl (
  input  logic          clk,
  input  logic          rst,
  gpr_wb_ctrl_if.slave  bus
);

  logic [31:1] busy;      // x0 never tracked
  logic [31:0] busy_vec;  // full-index view with bit 0 tied low
  logic        prio;      // 0: EXU wins a tie, 1: LSU wins a tie

  logic        grant_exu;
  logic        grant_lsu;
  logic        grant_any;
  logic [4:0]  sel_rd;
  logic        issue_set;
  logic        rs1_haz;
  logic        rs2_haz;
  logic        waw_haz;

  assign busy_vec = {busy, 1'b0};

  // Hazard check against the scoreboard; independent of iss_valid
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rs1_haz = 1'b0;
    rs2_haz = 1'b0;
    waw_haz = 1'b0;
    if (bus.iss_rs1 != 5'd0) rs1_haz = busy_vec[bus.iss_rs1];
    if (bus.iss_rs2 != 5'd0) rs2_haz = busy_vec[bus.iss_rs2];
    if (bus.iss_wen && bus.iss_rd != 5'd0) waw_haz = busy_vec[bus.iss_rd];
  end

  assign bus.iss_ready = !rst && !rs1_haz && !rs2_haz && !waw_haz;
  assign issue_set     = bus.iss_valid && bus.iss_ready && bus.iss_wen &&
                         (bus.iss_rd != 5'd0);

  // Round-robin grant: a lone requester always wins, prio breaks ties
  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst) begin
      if (bus.exu_valid && bus.lsu_valid) begin
        grant_exu = !prio;
        grant_lsu = prio;
      end else begin
        grant_exu = bus.exu_valid;
        grant_lsu = bus.lsu_valid;
      end
    end
  end

  assign grant_any     = grant_exu || grant_lsu;
  assign sel_rd        = grant_exu ? bus.exu_rd : bus.lsu_rd;
  assign bus.exu_ready = grant_exu;
  assign bus.lsu_ready = grant_lsu;
  assign bus.idle      = (busy == '0) && !bus.reg_write;

  // Write stage, arbitration pointer and orphan-write error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      bus.reg_write <= 1'b0;
      bus.rd_addr   <= '0;
      bus.rd_data   <= '0;
      prio          <= 1'b0;
      bus.err       <= 1'b0;
    end else if (grant_any) begin
      bus.reg_write <= (sel_rd != 5'd0);
      bus.rd_addr   <= sel_rd;
      bus.rd_data   <= grant_exu ? bus.exu_data : bus.lsu_data;
      prio          <= grant_exu;  // point at the loser for the next tie
      if (sel_rd != 5'd0 && !busy_vec[sel_rd]) bus.err <= 1'b1;
    end else begin
      bus.reg_write <= 1'b0;
    end
  end

  // Scoreboard: clear on the edge the file captures the data, set on issue (set wins)
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (issue_set && bus.iss_rd == 5'(i)) begin
          busy[i] <= 1'b1;
        end else if (bus.reg_write && bus.rd_addr == 5'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed bench for gpr_wb_ctrl: a hazard-check vector table plus
// hand-written sequences for write-back timing, arbitration, x0, WAW,
// orphan writes and reset mid-write.
module tb_gpr_wb_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gpr_wb_ctrl_if #(.XLEN(32)) bus ();

  gpr_wb_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wen;
    logic       exp_ready;
  } haz_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling
  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.iss_valid = 0; bus.iss_wen = 0; bus.iss_rd = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0;
    bus.exu_valid = 0; bus.exu_rd = 0; bus.exu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issue a writing instruction with no sources for one cycle
  task automatic issue_rd(input logic [4:0] rd);
    bus.iss_valid = 1; bus.iss_wen = 1; bus.iss_rd = rd; bus.iss_rs1 = 0; bus.iss_rs2 = 0;
    settle();
    check($sformatf("issue_ready_x%0d", rd), 32'(bus.iss_ready), 32'd1);
    tick();
    bus.iss_valid = 0; bus.iss_wen = 0; bus.iss_rd = 0;
  endtask

  // Retire rd through the LSU (held alone, so granted at once)
  task automatic lsu_retire(input logic [4:0] rd, input logic [31:0] data);
    bus.lsu_valid = 1; bus.lsu_rd = rd; bus.lsu_data = data;
    settle();
    check($sformatf("retire_lsu_ready_x%0d", rd), 32'(bus.lsu_ready), 32'd1);
    tick();
    bus.lsu_valid = 0;
  endtask

  haz_vec_t vecs[8];

  logic [4:0]  e_rd[3], l_rd[3];
  logic [31:0] e_dat[3], l_dat[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{rs1: 5'd0,  rs2: 5'd0,  rd: 5'd0,  wen: 1'b0, exp_ready: 1'b1};
    vecs[1] = '{rs1: 5'd3,  rs2: 5'd0,  rd: 5'd0,  wen: 1'b0, exp_ready: 1'b0};
    vecs[2] = '{rs1: 5'd0,  rs2: 5'd12, rd: 5'd0,  wen: 1'b0, exp_ready: 1'b0};
    vecs[3] = '{rs1: 5'd0,  rs2: 5'd0,  rd: 5'd31, wen: 1'b1, exp_ready: 1'b0};
    vecs[4] = '{rs1: 5'd0,  rs2: 5'd0,  rd: 5'd31, wen: 1'b0, exp_ready: 1'b1};
    vecs[5] = '{rs1: 5'd4,  rs2: 5'd5,  rd: 5'd6,  wen: 1'b1, exp_ready: 1'b1};
    vecs[6] = '{rs1: 5'd0,  rs2: 5'd0,  rd: 5'd0,  wen: 1'b1, exp_ready: 1'b1};
    vecs[7] = '{rs1: 5'd31, rs2: 5'd30, rd: 5'd29, wen: 1'b1, exp_ready: 1'b0};

    clear_inputs();

    // ---- Reset then idle; ready outputs forced low during reset
    rst = 1'b1;
    bus.exu_valid = 1; bus.lsu_valid = 1;
    tick();
    settle();
    check("rst_exu_ready", 32'(bus.exu_ready), 32'd0);
    check("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    check("rst_iss_ready", 32'(bus.iss_ready), 32'd0);
    tick();
    clear_inputs();
    rst = 1'b0;
    bus.iss_rs1 = 5; bus.iss_rs2 = 9; bus.iss_rd = 3; bus.iss_wen = 1;
    settle();
    check("reset_reg_write", 32'(bus.reg_write), 32'd0);
    check("reset_rd_addr",   32'(bus.rd_addr),   32'd0);
    check("reset_rd_data",   bus.rd_data,        32'd0);
    check("reset_idle",      32'(bus.idle),      32'd1);
    check("reset_err",       32'(bus.err),       32'd0);
    check("reset_iss_ready", 32'(bus.iss_ready), 32'd1);
    clear_inputs();

    // ---- Hazard table: x3, x12, x31 busy
    issue_rd(5'd3);
    issue_rd(5'd12);
    issue_rd(5'd31);
    check("table_not_idle", 32'(bus.idle), 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.iss_rs1 = vecs[i].rs1; bus.iss_rs2 = vecs[i].rs2;
      bus.iss_rd  = vecs[i].rd;  bus.iss_wen = vecs[i].wen;
      settle();
      check($sformatf("haz_vec%0d", i), 32'(bus.iss_ready), 32'(vecs[i].exp_ready));
    end
    clear_inputs();
    lsu_retire(5'd3, 32'h3);
    lsu_retire(5'd12, 32'hC);
    lsu_retire(5'd31, 32'h1F);
    tick();
    check("table_idle_after", 32'(bus.idle), 32'd1);
    check("table_err", 32'(bus.err), 32'd0);

    // ---- RAW stall with write-back latency
    do_reset();
    bus.iss_valid = 1; bus.iss_wen = 1; bus.iss_rd = 5;                 // cycle 1
    settle();
    check("raw_c1_ready", 32'(bus.iss_ready), 32'd1);
    tick();
    bus.iss_wen = 0; bus.iss_rd = 0; bus.iss_rs1 = 5;                   // cycle 2
    settle();
    check("raw_c2_ready", 32'(bus.iss_ready), 32'd0);
    tick();
    bus.exu_valid = 1; bus.exu_rd = 5; bus.exu_data = 32'hDEADBEEF;    // cycle 3
    settle();
    check("raw_c3_ready", 32'(bus.iss_ready), 32'd0);
    check("raw_c3_exu_ready", 32'(bus.exu_ready), 32'd1);
    tick();
    bus.exu_valid = 0;                                                  // cycle 4
    settle();
    check("raw_c4_ready", 32'(bus.iss_ready), 32'd0);
    check("raw_c4_reg_write", 32'(bus.reg_write), 32'd1);
    check("raw_c4_rd_addr", 32'(bus.rd_addr), 32'd5);
    check("raw_c4_rd_data", bus.rd_data, 32'hDEADBEEF);
    tick();                                                             // cycle 5
    settle();
    check("raw_c5_ready", 32'(bus.iss_ready), 32'd1);
    check("raw_c5_reg_write", 32'(bus.reg_write), 32'd0);
    tick();
    clear_inputs();
    check("raw_idle", 32'(bus.idle), 32'd1);

    // ---- Tie arbitration from reset: EXU first, then LSU
    do_reset();
    issue_rd(5'd1);
    issue_rd(5'd2);
    bus.exu_valid = 1; bus.exu_rd = 1; bus.exu_data = 32'h11;
    bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'h22;
    settle();
    check("tie_g1_exu", 32'(bus.exu_ready), 32'd1);
    check("tie_g1_lsu", 32'(bus.lsu_ready), 32'd0);
    tick();
    bus.exu_valid = 0;
    settle();
    check("tie_g2_lsu", 32'(bus.lsu_ready), 32'd1);
    check("tie_w1_addr", 32'(bus.rd_addr), 32'd1);
    check("tie_w1_data", bus.rd_data, 32'h11);
    check("tie_w1_we", 32'(bus.reg_write), 32'd1);
    tick();
    bus.lsu_valid = 0;
    settle();
    check("tie_w2_addr", 32'(bus.rd_addr), 32'd2);
    check("tie_w2_data", bus.rd_data, 32'h22);
    check("tie_w2_we", 32'(bus.reg_write), 32'd1);
    check("tie_err", 32'(bus.err), 32'd0);
    tick();

    // ---- Sustained contention: prio is back at 0, so E,L,E,L,E,L
    for (int i = 0; i < 3; i++) begin
      e_rd[i] = 5'(10 + 2 * i); e_dat[i] = 32'hE000_0000 + 32'(i);
      l_rd[i] = 5'(11 + 2 * i); l_dat[i] = 32'h1000_0000 + 32'(i);
    end
    for (int r = 10; r < 16; r++) issue_rd(5'(r));
    begin
      int ei = 0;
      int li = 0;
      logic exp_e = 1'b1;
      logic [4:0]  last_rd = 0;
      logic [31:0] last_dat = 0;
      for (int c = 0; c < 6; c++) begin
        bus.exu_valid = 1; bus.exu_rd = e_rd[ei]; bus.exu_data = e_dat[ei];
        bus.lsu_valid = 1; bus.lsu_rd = l_rd[li]; bus.lsu_data = l_dat[li];
        settle();
        check($sformatf("cont%0d_exu_ready", c), 32'(bus.exu_ready), 32'(exp_e));
        check($sformatf("cont%0d_lsu_ready", c), 32'(bus.lsu_ready), 32'(!exp_e));
        if (c > 0) begin
          check($sformatf("cont%0d_we", c), 32'(bus.reg_write), 32'd1);
          check($sformatf("cont%0d_addr", c), 32'(bus.rd_addr), 32'(last_rd));
          check($sformatf("cont%0d_data", c), bus.rd_data, last_dat);
        end
        if (exp_e) begin
          last_rd = e_rd[ei]; last_dat = e_dat[ei]; ei = (ei < 2) ? ei + 1 : ei;
        end else begin
          last_rd = l_rd[li]; last_dat = l_dat[li]; li = (li < 2) ? li + 1 : li;
        end
        exp_e = !exp_e;
        tick();
      end
      bus.exu_valid = 0; bus.lsu_valid = 0;
      settle();
      check("cont_last_we", 32'(bus.reg_write), 32'd1);
      check("cont_last_addr", 32'(bus.rd_addr), 32'(last_rd));
      check("cont_last_data", bus.rd_data, last_dat);
    end
    tick();
    check("cont_idle", 32'(bus.idle), 32'd1);
    check("cont_err", 32'(bus.err), 32'd0);

    // ---- x0 and WAW
    issue_rd(5'd0);
    settle();
    check("x0_no_busy", 32'(bus.idle), 32'd1);
    bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_data = 32'h55;
    settle();
    check("x0_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    tick();
    bus.lsu_valid = 0;
    settle();
    check("x0_reg_write", 32'(bus.reg_write), 32'd0);
    check("x0_err", 32'(bus.err), 32'd0);
    issue_rd(5'd7);
    bus.iss_valid = 1; bus.iss_wen = 1; bus.iss_rd = 7;
    settle();
    check("waw_stall1", 32'(bus.iss_ready), 32'd0);
    tick();
    bus.exu_valid = 1; bus.exu_rd = 7; bus.exu_data = 32'h77;
    settle();
    check("waw_stall2", 32'(bus.iss_ready), 32'd0);
    check("waw_exu_ready", 32'(bus.exu_ready), 32'd1);
    tick();
    bus.exu_valid = 0;
    settle();
    check("waw_stall3", 32'(bus.iss_ready), 32'd0);
    check("waw_we", 32'(bus.reg_write), 32'd1);
    check("waw_addr", 32'(bus.rd_addr), 32'd7);
    tick();
    settle();
    check("waw_release", 32'(bus.iss_ready), 32'd1);
    tick();
    clear_inputs();
    settle();
    check("waw_rebusy", 32'(bus.idle), 32'd0);
    bus.exu_valid = 1; bus.exu_rd = 7; bus.exu_data = 32'h78;
    tick();
    bus.exu_valid = 0;
    tick();
    check("waw_idle", 32'(bus.idle), 32'd1);
    check("waw_err", 32'(bus.err), 32'd0);

    // ---- Orphan write sets sticky err
    bus.exu_valid = 1; bus.exu_rd = 9; bus.exu_data = 32'h99;
    settle();
    check("orph_exu_ready", 32'(bus.exu_ready), 32'd1);
    tick();
    bus.exu_valid = 0;
    settle();
    check("orph_err", 32'(bus.err), 32'd1);
    check("orph_addr", 32'(bus.rd_addr), 32'd9);
    tick();
    tick();
    check("orph_err_sticky", 32'(bus.err), 32'd1);

    // ---- Reset mid-write: pending write dropped, busy cleared
    issue_rd(5'd21);
    issue_rd(5'd20);
    bus.exu_valid = 1; bus.exu_rd = 20; bus.exu_data = 32'hAA;
    tick();
    bus.exu_valid = 0;
    rst = 1'b1;  // write for x20 is in the write stage this cycle
    settle();
    check("mid_we_before", 32'(bus.reg_write), 32'd1);
    tick();
    rst = 1'b0;
    bus.iss_rs1 = 21; bus.iss_rs2 = 20; bus.iss_rd = 21; bus.iss_wen = 1;
    settle();
    check("mid_reg_write", 32'(bus.reg_write), 32'd0);
    check("mid_err", 32'(bus.err), 32'd0);
    check("mid_idle", 32'(bus.idle), 32'd1);
    check("mid_iss_ready", 32'(bus.iss_ready), 32'd1);
    clear_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
